// File: rtl/serial_decrement_if.sv
// Operand/result handshake bundle for the bit-serial decrementer.
interface serial_decrement_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             bout;

    modport master (
        output in_valid,
        output a,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y,
        input  bout
    );

    modport slave (
        input  in_valid,
        input  a,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y,
        output bout
    );
endinterface

// File: rtl/serial_decrement.sv
// Bit-serial decrement: y = a - 1 mod 2^WIDTH, one bit per cycle, fixed WIDTH-cycle latency.
module serial_decrement #(
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    serial_decrement_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           r_state, w_state_next;
    logic [WIDTH-1:0] r_shift, w_shift_next;
    logic             r_borrow, w_borrow_next;
    logic [CntW-1:0]  r_cnt, w_cnt_next;
    logic             w_res_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_shift  <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_borrow <= w_borrow_next;
            r_cnt    <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_borrow_next = r_borrow;
        w_cnt_next    = r_cnt;
        w_res_bit     = r_shift[0] ^ r_borrow;
        case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_shift_next  = bus.a;
                    w_borrow_next = 1'b1;
                    w_cnt_next    = '0;
                    w_state_next  = StBusy;
                end
            end
            StBusy: begin
                // Result bits enter at the MSB so the register holds y after WIDTH shifts
                w_shift_next  = {w_res_bit, r_shift[WIDTH-1:1]};
                w_borrow_next = ~r_shift[0] & r_borrow;
                w_cnt_next    = r_cnt + CntW'(1);
                if (r_cnt == CntW'(WIDTH - 1)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.y         = r_shift;
    assign bus.bout      = r_borrow;
endmodule

// File: tb/tb_serial_decrement.sv
// Bench for serial_decrement: directed literal cases plus random traffic against a transaction model.
module tb_serial_decrement;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_decrement_if #(.WIDTH(W)) bus ();

    serial_decrement #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction model: operand in flight, countdown to result, last presented result
    bit           m_known = 1'b0;
    bit           m_inflight = 1'b0;
    bit           m_valid = 1'b0;
    int           m_wait = 0;
    logic [W-1:0] m_y = '0;
    logic [W-1:0] m_res = '0;
    logic         m_b = 1'b0;
    logic         m_resb = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_known    = 1'b1;
            m_inflight = 1'b0;
            m_valid    = 1'b0;
            m_wait     = 0;
            m_y        = '0;
            m_b        = 1'b0;
        end else if (m_known) begin
            if (!m_inflight) begin
                if (bus.in_valid) begin
                    m_inflight = 1'b1;
                    m_wait     = W;
                    m_res      = W'(int'(bus.a) - 1);
                    m_resb     = (bus.a == '0);
                end
            end else if (!m_valid) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_valid = 1'b1;
                    m_y     = m_res;
                    m_b     = m_resb;
                end
            end else if (bus.out_ready) begin
                m_valid    = 1'b0;
                m_inflight = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("in_ready", bus.in_ready, !m_inflight);
            chk("out_valid", bus.out_valid, m_valid);
            if (!m_inflight || m_valid) begin
                chk("y", bus.y, m_y);
                chk("bout", bus.bout, m_b);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] aval, input logic [W-1:0] ey, input logic eb,
                          input int hold);
        int n;
        bus.a        = aval;
        bus.in_valid = 1'b1;
        bus.out_ready = (hold == 0);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        step();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 4 * W) begin
            step();
            n++;
        end
        chk("latency", n, W);
        chk("y_lit", bus.y, ey);
        chk("bout_lit", bus.bout, eb);
        for (int i = 0; i < hold; i++) begin
            chk("hold_y", bus.y, ey);
            chk("hold_bout", bus.bout, eb);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            if (i < hold - 1) step();
        end
        bus.out_ready = 1'b1;
        step();
        chk("post_valid", bus.out_valid, 0);
        chk("post_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        int n;
        int acc[$];
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_bout", bus.bout, 0);

        run_op(8'h05, 8'h04, 1'b0, 0);
        run_op(8'h00, 8'hFF, 1'b1, 0);
        run_op(8'h80, 8'h7F, 1'b0, 0);
        run_op(8'h01, 8'h00, 1'b0, 0);
        run_op(8'h10, 8'h0F, 1'b0, 5);

        // Second operand offered throughout BUSY must wait for IDLE
        bus.a         = 8'h33;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.a = 8'hAA;
        n = 0;
        while (!bus.out_valid && n < 4 * W) begin
            chk("busy_in_ready", bus.in_ready, 0);
            step();
            n++;
        end
        chk("ovl_latency", n, W);
        chk("ovl_y", bus.y, 8'h32);
        step();
        chk("ovl_idle", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk("ovl_accept", bus.in_ready, 0);
        n = 0;
        while (!bus.out_valid && n < 4 * W) begin
            step();
            n++;
        end
        chk("ovl2_latency", n, W);
        chk("ovl2_y", bus.y, 8'hA9);
        chk("ovl2_bout", bus.bout, 0);
        step();

        // Reset in BUSY cycle 3 discards the operand
        bus.a        = 8'h5A;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_in_ready", bus.in_ready, 1);
        chk("mrst_y", bus.y, 0);
        chk("mrst_bout", bus.bout, 0);
        for (int i = 0; i < 2 * W; i++) begin
            step();
            chk("mrst_no_result", bus.out_valid, 0);
        end

        // Back-to-back throughput
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 4 * (W + 2) + 2; cyc++) begin
            bus.a = W'($urandom);
            if (bus.in_ready) acc.push_back(cyc);
            step();
        end
        bus.in_valid = 1'b0;
        chk("b2b_count", acc.size() >= 4, 1);
        for (int i = 1; i < acc.size(); i++) begin
            chk("b2b_spacing", acc[i] - acc[i-1], W + 2);
        end
        for (int i = 0; i < W + 3; i++) step();

        // Random traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.a         = W'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst_n         = ($urandom_range(0, 80) != 0);
            step();
        end
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/serial_decrement.md
SERIAL_DECREMENT -- requirements
Module: serial_decrement

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: in_valid  input  1  operand offered on a.
REQ-005 Port: in_ready  output  1  block can accept an operand.
REQ-006 Port: a  input  WIDTH  operand to be decremented.
REQ-007 Port: out_valid  output  1  result presented on y/bout.
REQ-008 Port: out_ready  input  1  consumer accepts result.
REQ-009 Port: y  output  WIDTH  result, a - 1 modulo 2^WIDTH.
REQ-010 Port: bout  output  1  borrow out; 1 iff captured a == 0.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-012 IDLE: in_ready = 1, out_valid = 0.
REQ-013 Input transfer SHALL occur on a rising edge with in_valid & in_ready; this edge (T0) SHALL capture a into a WIDTH-bit shift register, set the borrow flop to 1, clear the bit counter, and enter BUSY.
REQ-014 BUSY: in_ready = 0, out_valid = 0; in_valid and a SHALL be ignored.
REQ-015 Each BUSY cycle SHALL process the shift-register LSB: result bit = lsb XOR borrow; next borrow = (NOT lsb) AND borrow.
REQ-016 Each BUSY cycle SHALL shift the register right one place, inserting the result bit at the MSB.
REQ-017 The bit counter SHALL be ceil(log2(WIDTH+1)) bits and increment once per BUSY cycle.
REQ-018 BUSY SHALL last exactly WIDTH cycles; the edge completing bit WIDTH-1 SHALL enter DONE.
REQ-019 out_valid SHALL first be high in the cycle after edge T0+WIDTH; latency is fixed and independent of operand value (no early exit).
REQ-020 DONE: out_valid = 1, in_ready = 0, y = shift register contents, bout = final borrow flop.
REQ-021 y and bout SHALL remain stable while out_valid = 1 and out_ready = 0 (indefinite backpressure).
REQ-022 Output transfer SHALL occur on a rising edge with out_valid & out_ready; the FSM SHALL then enter IDLE.
REQ-023 There SHALL be no input/output overlap: at most one operand in flight; throughput = one operand per WIDTH+2 cycles minimum.
REQ-024 y and bout SHALL retain their last values in IDLE; consumers use them only when out_valid = 1.
REQ-025 Wrap-around: a = 0 SHALL give y = all ones, bout = 1; every other a SHALL give y = a - 1, bout = 0.
REQ-026 The FSM SHALL contain no unreachable-state lockup; an illegal state encoding SHALL return to IDLE on the next edge.

Reset
REQ-027 On a rising edge with rst_n = 0 the block SHALL enter IDLE and clear shift register, borrow flop, and bit counter, so that y = 0, bout = 0, out_valid = 0, in_ready = 1 on the next cycle.
REQ-028 Reset SHALL take priority over all other inputs, including a simultaneous input or output transfer.
REQ-029 Reset asserted in BUSY or DONE SHALL discard the in-flight operand without producing out_valid.
REQ-030 After rst_n returns high, the first edge with in_valid = 1 SHALL accept an operand.

Verification
REQ-031 The bench SHALL cover: WIDTH=8, a=8'h05 accepted at T0, out_ready=1 -> out_valid high in the cycle after T0+8, y=8'h04, bout=0, IDLE one edge later.
REQ-032 The bench SHALL cover: a=8'h00 -> y=8'hFF, bout=1; a=8'h80 -> y=8'h7F, bout=0; a=8'h01 -> y=8'h00, bout=0.
REQ-033 The bench SHALL cover: a=8'h10, out_ready held 0 for 5 cycles after out_valid rises -> y=8'h0F, bout=0 stable all 5 cycles, in_ready=0 throughout, transfer on first out_ready=1 edge.
REQ-034 The bench SHALL cover: a=8'h33 accepted, then in_valid=1 with a=8'hAA during all of BUSY -> result y=8'h32; 8'hAA not accepted until back in IDLE.
REQ-035 The bench SHALL cover: rst_n=0 for one edge at BUSY cycle 3 -> next cycle out_valid=0, in_ready=1, y=0, bout=0; no result ever emitted for that operand.
REQ-036 The bench SHALL cover: back-to-back operands with in_valid and out_ready tied high -> accepts spaced exactly WIDTH+2 cycles apart.
